// File: rtl/mini_2_pkg.sv
// Shared width defaults and reference code-conversion helpers for mini_2.
package mini_2_pkg;

    localparam int WIDTH_DEF = 3;
    localparam int MAX_W     = 16;

    // Helpers work on a fixed 16-bit container; bits at or above w are masked off.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] value, input int w);
        logic [MAX_W-1:0] m;
        m = {MAX_W{1'b1}} >> (MAX_W - w);
        return (value & m) ^ ((value & m) >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] value, input int w);
        logic [MAX_W-1:0] m;
        logic [MAX_W-1:0] r;
        m = {MAX_W{1'b1}} >> (MAX_W - w);
        r = value & m;
        for (int i = MAX_W - 2; i >= 0; i--) begin
            r[i] = r[i] ^ r[i+1];
        end
        return r;
    endfunction

endpackage

// File: rtl/mini_2_gray2bin.sv
// Combinational Gray->binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module mini_2_gray2bin
    import mini_2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Reduction per bit instead of a rippled chain keeps each bit free of self-referencing nets.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/mini_2.sv
// Registered binary<->Gray converter with a change flag.
// Optional registered input parity output enabled by MINI_2_PARITY_EN.
module mini_2
    import mini_2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             dir,
    output logic [WIDTH-1:0] b,
    output logic             chg
`ifdef MINI_2_PARITY_EN
    ,
    output logic             parity
`endif
);

    logic [MAX_W-1:0] gray_wide;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] conv;

    assign gray_wide = bin2gray(MAX_W'(a), WIDTH);
    assign gray      = gray_wide[WIDTH-1:0];

    mini_2_gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray (a),
        .bin  (bin)
    );

    always_comb begin
        conv = gray;
        if (dir) conv = bin;
    end

    // Reset branch assigns constants only, so unknown inputs under reset never reach the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            b   <= '0;
            chg <= 1'b0;
        end else begin
            b   <= conv;
            chg <= (conv != b);
        end
    end

`ifdef MINI_2_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) parity <= 1'b0;
        else     parity <= ^a;
    end
`endif

endmodule

// File: tb/tb_mini_2.sv
// Scoreboard bench for mini_2: expected outputs queued at drive time, popped one edge later.
module tb_mini_2;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a   = '0;
    logic         dir = 1'b0;
    logic [W-1:0] b;
    logic         chg;
`ifdef MINI_2_PARITY_EN
    logic         parity;
`else
    logic         parity = 1'b0;
`endif

    mini_2 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .dir    (dir),
        .b      (b),
        .chg    (chg)
`ifdef MINI_2_PARITY_EN
        ,
        .parity (parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] b;
        logic         chg;
        logic         par;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_b = '0;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_conv(input logic d, input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         acc;
        if (!d) begin
            r[W-1] = v[W-1];
            for (int i = 0; i < W - 1; i++) r[i] = v[i] ^ v[i+1];
        end else begin
            acc = 1'b0;
            for (int i = W - 1; i >= 0; i--) begin
                acc  = acc ^ v[i];
                r[i] = acc;
            end
        end
        return r;
    endfunction

    // Drive one cycle, queue the model's prediction, then check what the DUT shows after the edge.
    task automatic step(input logic r, input logic d, input logic [W-1:0] v, input string tag);
        exp_t e;
        exp_t o;
        @(negedge clk);
        rst = r;
        dir = d;
        a   = v;
        if (r) begin
            e.b = '0; e.chg = 1'b0; e.par = 1'b0;
        end else begin
            e.b = ref_conv(d, v); e.chg = (e.b != m_b); e.par = ^v;
        end
        m_b = e.b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            o = sb.pop_front();
            chk({tag, "_b"}, 32'(b), 32'(o.b));
            chk({tag, "_chg"}, 32'(chg), 32'(o.chg));
`ifdef MINI_2_PARITY_EN
            chk({tag, "_par"}, 32'(parity), 32'(o.par));
`endif
        end
    endtask

    int gray_tab[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    initial begin
        // Reset for two cycles with a=5, then with unknown input.
        step(1'b1, 1'b0, 3'd5, "rst0");
        step(1'b1, 1'b0, 3'd5, "rst1");
        chk("rst_b_const", 32'(b), 32'd0);
        step(1'b1, 1'b1, 3'bxxx, "rst_x");
        chk("rst_x_b_known", 32'(^b === 1'bx), 32'd0);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, W'(i), "bsweep");
            chk("bsweep_tab", 32'(b), 32'(gray_tab[i]));
            chk("bsweep_chg_tab", 32'(chg), 32'(i != 0));
        end

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, W'(gray_tab[i]), "gsweep");
            chk("gsweep_tab", 32'(b), 32'(i));
        end

        step(1'b0, 1'b0, 3'd7, "wrap7");
        chk("wrap7_const", {28'd0, b, chg}, {28'd0, 3'b100, 1'b1});
        step(1'b0, 1'b0, 3'd0, "wrap0");
        chk("wrap0_const", {28'd0, b, chg}, {28'd0, 3'b000, 1'b1});
        step(1'b0, 1'b0, 3'd0, "hold0");
        chk("hold0_const", {28'd0, b, chg}, {28'd0, 3'b000, 1'b0});

        step(1'b0, 1'b0, 3'd6, "mid_pre");
        step(1'b1, 1'b0, 3'd6, "mid_rst");
        chk("mid_rst_const", 32'(b), 32'd0);
        step(1'b0, 1'b1, 3'd6, "mid_flip");
        chk("mid_flip_const", 32'(b), 32'b100);

        for (int k = 0; k < 2; k++) begin
            step(1'b0, k[0], 3'd3, "par3");
            step(1'b0, k[0], 3'd7, "par7");
            step(1'b0, k[0], 3'd4, "par4");
        end

        // Random mix of direction, data and occasional reset.
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 9) == 0), 1'($urandom), W'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
